// File: rtl/cdb_arb_if.sv
// Functional-unit to common-data-bus signal bundle for cdb_arb.
// The CDB slot count comes from `CDB_WIDTH, which defaults to 4.
`ifndef CDB_WIDTH
`define CDB_WIDTH 4
`endif

interface cdb_arb_if #(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned PR_W    = 7,
    parameter int unsigned AR_W    = 5
);
    logic [NUM_REQ-1:0]      fu_req;
    logic [NUM_REQ*PR_W-1:0] fu_pr_tags;
    logic [NUM_REQ*AR_W-1:0] fu_ar_tags;
    logic [NUM_REQ-1:0]      fu_grant;
    logic [`CDB_WIDTH-1:0]   cdb_broadcast;
    logic [PR_W-1:0]         cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3;
    logic [AR_W-1:0]         cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3;

    // Functional-unit side.
    modport master (
        output fu_req, fu_pr_tags, fu_ar_tags,
        input  fu_grant, cdb_broadcast,
        input  cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3,
        input  cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3
    );

    // Arbiter side.
    modport slave (
        input  fu_req, fu_pr_tags, fu_ar_tags,
        output fu_grant, cdb_broadcast,
        output cdb_pr_tag0, cdb_pr_tag1, cdb_pr_tag2, cdb_pr_tag3,
        output cdb_ar_tag0, cdb_ar_tag1, cdb_ar_tag2, cdb_ar_tag3
    );
endinterface

// File: rtl/cdb_arb.sv
// Common-data-bus arbiter: grants up to 4 FU completions per cycle into packed CDB slots.
// Define CDB_ARB_RR_EN for rotating priority; otherwise requester 0 is always highest.
`ifndef CDB_WIDTH
`define CDB_WIDTH 4
`endif

module cdb_arb #(
    parameter int unsigned NUM_REQ = 6,
    parameter int unsigned PR_W    = 7,
    parameter int unsigned AR_W    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       recover,
    cdb_arb_if.slave   bus
);
    localparam int unsigned CDB_W = `CDB_WIDTH;
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [CDB_W-1:0]            bcast_q, bcast_d;
    logic [CDB_W-1:0][PR_W-1:0]  pr_q, pr_d;
    logic [CDB_W-1:0][AR_W-1:0]  ar_q, ar_d;
    logic [NUM_REQ-1:0]          grant_c;
    logic [PR_W-1:0]             pr_arr [NUM_REQ];
    logic [AR_W-1:0]             ar_arr [NUM_REQ];
    logic [PTR_W-1:0]            idx;
    logic [2:0]                  cnt;
`ifdef CDB_ARB_RR_EN
    logic [PTR_W-1:0]            last;
`endif

    // Split the packed tag buses into per-requester entries.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            pr_arr[i] = bus.fu_pr_tags[i*PR_W +: PR_W];
            ar_arr[i] = bus.fu_ar_tags[i*AR_W +: AR_W];
        end
    end

    // Scan from ptr with wrap, pack the first CDB_W requesters found into slots in scan order.
    always_comb begin
        grant_c = '0;
        bcast_d = '0;
        pr_d    = '0;
        ar_d    = '0;
        ptr_d   = ptr_q;
        idx     = '0;
        cnt     = '0;
`ifdef CDB_ARB_RR_EN
        last    = ptr_q;
`endif
        if (recover) begin
            ptr_d = '0;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
                if (bus.fu_req[idx] && (cnt < 3'(CDB_W))) begin
                    grant_c[idx]        = 1'b1;
                    bcast_d[cnt[1:0]]   = 1'b1;
                    pr_d[cnt[1:0]]      = pr_arr[idx];
                    ar_d[cnt[1:0]]      = ar_arr[idx];
`ifdef CDB_ARB_RR_EN
                    last                = idx;
`endif
                    cnt                 = cnt + 3'd1;
                end
            end
`ifdef CDB_ARB_RR_EN
            if (cnt != 3'd0) begin
                ptr_d = (last == PTR_W'(NUM_REQ - 1)) ? '0 : last + PTR_W'(1);
            end
`else
            ptr_d = '0;
`endif
        end
    end

    // Grants are suppressed for the whole time reset is held.
    assign bus.fu_grant = reset ? grant_c : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q   <= '0;
            bcast_q <= '0;
            pr_q    <= '0;
            ar_q    <= '0;
        end else begin
            ptr_q   <= ptr_d;
            bcast_q <= bcast_d;
            pr_q    <= pr_d;
            ar_q    <= ar_d;
        end
    end

    assign bus.cdb_broadcast = bcast_q;
    assign bus.cdb_pr_tag0   = pr_q[0];
    assign bus.cdb_pr_tag1   = pr_q[1];
    assign bus.cdb_pr_tag2   = pr_q[2];
    assign bus.cdb_pr_tag3   = pr_q[3];
    assign bus.cdb_ar_tag0   = ar_q[0];
    assign bus.cdb_ar_tag1   = ar_q[1];
    assign bus.cdb_ar_tag2   = ar_q[2];
    assign bus.cdb_ar_tag3   = ar_q[3];

endmodule

// File: tb/tb_cdb_arb.sv
// Directed self-checking bench for cdb_arb; expectations follow CDB_ARB_RR_EN.
module tb_cdb_arb;
    localparam int unsigned NUM_REQ = 6;
    localparam int unsigned PR_W    = 7;
    localparam int unsigned AR_W    = 5;

    logic clock   = 1'b0;
    logic reset   = 1'b1;
    logic recover = 1'b0;
    int   n_cmp   = 0;
    int   n_mis   = 0;

    always #5 clock = ~clock;

    cdb_arb_if #(.NUM_REQ(NUM_REQ), .PR_W(PR_W), .AR_W(AR_W)) bus ();

    cdb_arb #(.NUM_REQ(NUM_REQ), .PR_W(PR_W), .AR_W(AR_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .recover (recover),
        .bus     (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_tag(input int i, input logic [PR_W-1:0] pr, input logic [AR_W-1:0] ar);
        bus.fu_pr_tags[i*PR_W +: PR_W] = pr;
        bus.fu_ar_tags[i*AR_W +: AR_W] = ar;
    endtask

    // Requester i carries PR tag 40+i and AR tag 10+i.
    task automatic std_tags();
        for (int i = 0; i < NUM_REQ; i++) set_tag(i, PR_W'(40 + i), AR_W'(10 + i));
    endtask

    task automatic expect_cdb(input string tag, input logic [3:0] b,
                              input logic [3:0][PR_W-1:0] p, input logic [3:0][AR_W-1:0] a);
        check({tag, ".bcast"}, 32'(bus.cdb_broadcast), 32'(b));
        check({tag, ".pr0"},   32'(bus.cdb_pr_tag0),   32'(p[0]));
        check({tag, ".pr1"},   32'(bus.cdb_pr_tag1),   32'(p[1]));
        check({tag, ".pr2"},   32'(bus.cdb_pr_tag2),   32'(p[2]));
        check({tag, ".pr3"},   32'(bus.cdb_pr_tag3),   32'(p[3]));
        check({tag, ".ar0"},   32'(bus.cdb_ar_tag0),   32'(a[0]));
        check({tag, ".ar1"},   32'(bus.cdb_ar_tag1),   32'(a[1]));
        check({tag, ".ar2"},   32'(bus.cdb_ar_tag2),   32'(a[2]));
        check({tag, ".ar3"},   32'(bus.cdb_ar_tag3),   32'(a[3]));
    endtask

    // Drive a request vector at the falling edge, check the grant, advance one cycle.
    task automatic step(input string tag, input logic [NUM_REQ-1:0] req, input logic [NUM_REQ-1:0] exp_grant);
        bus.fu_req = req;
        #1;
        check({tag, ".grant"}, 32'(bus.fu_grant), 32'(exp_grant));
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        bus.fu_req = '1;
        std_tags();
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst.grant", 32'(bus.fu_grant), 32'd0);
        expect_cdb("rst", 4'b0000, '0, '0);

        reset = 1'b1;
        set_tag(0, 7'd32, 5'd3);
        set_tag(2, 7'd33, 5'd4);
        step("two", 6'b000101, 6'b000101);
        expect_cdb("two", 4'b0011, {7'd0, 7'd0, 7'd33, 7'd32}, {5'd0, 5'd0, 5'd4, 5'd3});

        std_tags();
        recover = 1'b1;
        step("rec", 6'b001111, 6'b000000);
        expect_cdb("rec", 4'b0000, '0, '0);
        recover = 1'b0;

        step("all1", 6'b111111, 6'b001111);
        expect_cdb("all1", 4'b1111, {7'd43, 7'd42, 7'd41, 7'd40}, {5'd13, 5'd12, 5'd11, 5'd10});

`ifdef CDB_ARB_RR_EN
        step("all2", 6'b111111, 6'b110011);
        expect_cdb("all2", 4'b1111, {7'd41, 7'd40, 7'd45, 7'd44}, {5'd11, 5'd10, 5'd15, 5'd14});
`else
        step("all2", 6'b111111, 6'b001111);
        expect_cdb("all2", 4'b1111, {7'd43, 7'd42, 7'd41, 7'd40}, {5'd13, 5'd12, 5'd11, 5'd10});
`endif

        step("idle", 6'b000000, 6'b000000);
        expect_cdb("idle", 4'b0000, '0, '0);

`ifdef CDB_ARB_RR_EN
        step("hold", 6'b000111, 6'b000111);
        expect_cdb("hold", 4'b0111, {7'd0, 7'd41, 7'd40, 7'd42}, {5'd0, 5'd11, 5'd10, 5'd12});
`else
        step("hold", 6'b000111, 6'b000111);
        expect_cdb("hold", 4'b0111, {7'd0, 7'd42, 7'd41, 7'd40}, {5'd0, 5'd12, 5'd11, 5'd10});
`endif

        set_tag(5, 7'd127, 5'd31);
        step("r5", 6'b100000, 6'b100000);
        expect_cdb("r5", 4'b0001, {7'd0, 7'd0, 7'd0, 7'd127}, {5'd0, 5'd0, 5'd0, 5'd31});

        std_tags();
        step("p0", 6'b111111, 6'b001111);
        expect_cdb("p0", 4'b1111, {7'd43, 7'd42, 7'd41, 7'd40}, {5'd13, 5'd12, 5'd11, 5'd10});

`ifdef CDB_ARB_RR_EN
        step("four", 6'b011110, 6'b011110);
        expect_cdb("four", 4'b1111, {7'd43, 7'd42, 7'd41, 7'd44}, {5'd13, 5'd12, 5'd11, 5'd14});
`else
        step("four", 6'b011110, 6'b011110);
        expect_cdb("four", 4'b1111, {7'd44, 7'd43, 7'd42, 7'd41}, {5'd14, 5'd13, 5'd12, 5'd11});
`endif

        // Asynchronous reset between edges, then restart from requester 0.
        bus.fu_req = '1;
        #2 reset = 1'b0;
        #1;
        check("mrst.grant", 32'(bus.fu_grant), 32'd0);
        check("mrst.bcast", 32'(bus.cdb_broadcast), 32'd0);
        check("mrst.pr0",   32'(bus.cdb_pr_tag0), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step("rel", 6'b111111, 6'b001111);
        expect_cdb("rel", 4'b1111, {7'd43, 7'd42, 7'd41, 7'd40}, {5'd13, 5'd12, 5'd11, 5'd10});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
